// File: rtl/common_types.sv
// Shared types and constants for the fetch stage.
package common_types;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam word_t RISCV_NOP = 32'h0000_0013;

    function automatic word_t word_align(input word_t a);
        return a & ~word_t'(32'd3);
    endfunction

endpackage

// File: rtl/dyt_fetch_skid.sv
// One-entry {instr, pc} holding buffer for a word fetched while decode is stalled.
// Registered output; load and clear take effect on the next rising edge, clear wins.
module dyt_fetch_skid
    import common_types::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  word_t in_instr,
    input  word_t in_pc,
    output word_t instr,
    output word_t pc,
    output logic  valid
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            instr <= RISCV_NOP;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/dyt_fetch_ctrl.sv
// Fetch sequencer: one-outstanding imem requests, skid buffer on stall, flush on redirect.
// Delivery is combinational in the ack cycle; a stalled word waits in the skid buffer.
module dyt_fetch_ctrl
    import common_types::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter word_t NOP_INSTR = RISCV_NOP
) (
    input  logic  CLK,
    input  logic  rst,
    output logic  imem_ren_o,
    output word_t imem_addr_o,
    input  word_t imem_rdata_i,
    input  logic  imem_ack_i,
    input  logic  stall_i,
    input  logic  redirect_i,
    input  word_t redirect_pc_i,
    output logic  ifid_en_o,
    output logic  ifid_flush_o,
    output word_t fetch_instr_o,
    output word_t fetch_pc_o,
    output word_t fetch_count_o
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    word_t        drain_addr, drain_addr_next;
    word_t        count;
    logic         count_inc;
    logic         skid_load, skid_clear, skid_valid;
    word_t        skid_instr, skid_pc;

    dyt_fetch_skid u_skid (
        .clk      (CLK),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_instr (imem_rdata_i),
        .in_pc    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .valid    (skid_valid)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= RST;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            count      <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            drain_addr <= drain_addr_next;
            if (count_inc) count <= count + 32'd1;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        drain_addr_next = drain_addr;
        count_inc       = 1'b0;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        imem_ren_o      = 1'b0;
        imem_addr_o     = pc;
        ifid_en_o       = 1'b0;
        ifid_flush_o    = 1'b0;
        fetch_instr_o   = NOP_INSTR;
        fetch_pc_o      = pc;

        case (state)
            RST: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_ren_o = 1'b1;
                if (imem_ack_i) begin
                    if (!stall_i) begin
                        ifid_en_o     = 1'b1;
                        fetch_instr_o = imem_rdata_i;
                        pc_next       = pc + 32'd4;
                        count_inc     = 1'b1;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_i && skid_valid) begin
                    ifid_en_o     = 1'b1;
                    fetch_instr_o = skid_instr;
                    fetch_pc_o    = skid_pc;
                    pc_next       = pc + 32'd4;
                    count_inc     = 1'b1;
                    skid_clear    = 1'b1;
                    state_next    = FETCH;
                end
            end
            DRAIN: begin
                // pc already holds the redirect target; the bus keeps the stale address
                imem_ren_o  = 1'b1;
                imem_addr_o = drain_addr;
                if (imem_ack_i) state_next = FETCH;
            end
            default: state_next = RST;
        endcase

        if (redirect_i) begin
            ifid_flush_o  = 1'b1;
            ifid_en_o     = 1'b1;
            fetch_instr_o = NOP_INSTR;
            fetch_pc_o    = pc;
            count_inc     = 1'b0;
            skid_load     = 1'b0;
            skid_clear    = 1'b1;
            pc_next       = word_align(redirect_pc_i);
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        state_next = FETCH;
                    end else begin
                        state_next      = DRAIN;
                        drain_addr_next = pc;
                    end
                end
                DRAIN:   state_next = imem_ack_i ? FETCH : DRAIN;
                default: state_next = FETCH;
            endcase
        end
    end

    assign fetch_count_o = count;

endmodule
